pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 80 ++++++++
 tb/tb_pc_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch address generation with stall back-pressure
// and a one-entry buffer that holds a redirect arriving while the pipeline is stalled.
module pc_unit #(
  parameter int unsigned     WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] INC       = WIDTH'(4)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             redir_valid_i,
  input  logic [WIDTH-1:0] redir_target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_seq_o,
  output logic             fetch_valid_o,
  output logic             flush_o,
  output logic             pend_o,
  output logic             misalign_o
);

  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [WIDTH-1:0] IncMask = INC - One;

  typedef enum logic [1:0] {StBoot, StRun, StStall, StStallPend} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] buf_q, buf_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (state_q == StBoot) begin
      // Leaving boot never advances pc; an early redirect is parked until the next edge.
      if (redir_valid_i) begin
        buf_d   = redir_target_i;
        state_d = StStallPend;
      end else begin
        state_d = StRun;
      end
    end else if (!stall_i) begin
      state_d = StRun;
      buf_d   = '0;
      if (redir_valid_i) begin
        pc_d = redir_target_i;
      end else if (state_q == StStallPend) begin
        pc_d = buf_q;
      end else begin
        pc_d = pc_seq_o;
      end
    end else if (redir_valid_i) begin
      buf_d   = redir_target_i;
      state_d = StStallPend;
    end else if (state_q == StRun) begin
      state_d = StStall;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StBoot;
      pc_q    <= RESET_VEC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_seq_o      = pc_q + INC;
  assign fetch_valid_o = (state_q != StBoot);
  assign pend_o        = (state_q == StStallPend);
  assign flush_o       = (state_q != StBoot) && !stall_i &&
                         (redir_valid_i || (state_q == StStallPend));
  assign misalign_o    = (pc_q & IncMask) != '0;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios then random traffic, all checked against a
// behavioural model of the fetch-address rules.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [63:0] redir_target = '0;
  logic [63:0] pc, pc_seq;
  logic        fetch_valid, flush, pend, misalign;

  int checks   = 0;
  int failures = 0;

  // Model state: booted = has left BOOT, pend/buffer = parked redirect.
  logic        m_booted = 1'b0;
  logic        m_pend   = 1'b0;
  logic [63:0] m_buf    = '0;
  logic [63:0] m_pc     = '0;

  pc_unit #(.WIDTH(64), .RESET_VEC(64'd0), .INC(64'd4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .redir_valid_i  (redir_valid),
    .redir_target_i (redir_target),
    .pc_o           (pc),
    .pc_seq_o       (pc_seq),
    .fetch_valid_o  (fetch_valid),
    .flush_o        (flush),
    .pend_o         (pend),
    .misalign_o     (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_pend"}, {63'd0, pend}, {63'd0, m_pend});
    chk({tag, "_fv"}, {63'd0, fetch_valid}, {63'd0, m_booted});
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [63:0] tgt);
    if (!m_booted) begin
      m_booted = 1'b1;
      if (rv) begin
        m_pend = 1'b1;
        m_buf  = tgt;
      end
    end else if (!s) begin
      m_pc   = rv ? tgt : (m_pend ? m_buf : m_pc + 64'd4);
      m_pend = 1'b0;
    end else if (rv) begin
      m_pend = 1'b1;
      m_buf  = tgt;
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones after posedge.
  task automatic step(input logic s, input logic rv, input logic [63:0] tgt, input string tag);
    logic exp_flush;
    @(negedge clk);
    stall        = s;
    redir_valid  = rv;
    redir_target = tgt;
    #1;
    exp_flush = m_booted && !s && (rv || m_pend);
    chk({tag, "_flush"}, {63'd0, flush}, {63'd0, exp_flush});
    chk({tag, "_seq"}, pc_seq, m_pc + 64'd4);
    chk({tag, "_mis"}, {63'd0, misalign}, {63'd0, (m_pc % 64'd4) != 64'd0});
    chk_regs({tag, "_pre"});
    model_edge(s, rv, tgt);
    @(posedge clk);
    #1;
    chk_regs({tag, "_post"});
  endtask

  // Asynchronous reset pulse placed between a posedge and the following negedge.
  task automatic reset_pulse(input string tag);
    #1;
    rst          = 1'b1;
    stall        = 1'($urandom);
    redir_valid  = 1'($urandom);
    redir_target = {$urandom, $urandom};
    #1;
    m_booted = 1'b0;
    m_pend   = 1'b0;
    m_buf    = '0;
    m_pc     = '0;
    chk_regs({tag, "_rst"});
    chk({tag, "_rst_flush"}, {63'd0, flush}, 64'd0);
    stall       = 1'b0;
    redir_valid = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] t;
    // Reset held across edges with random inputs: pc pinned, no flush.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall        = 1'($urandom);
      redir_valid  = 1'($urandom);
      redir_target = {$urandom, $urandom};
      #1;
      chk("hold_flush", {63'd0, flush}, 64'd0);
      @(posedge clk);
      #1;
      chk_regs("hold");
    end
    stall       = 1'b0;
    redir_valid = 1'b0;
    rst         = 1'b0;

    // Boot exit and sequential run: 0,0,4,8,12.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'hDEAD_BEEF, "seq");
    chk("seq_pc12", pc, 64'd12);

    // Redirect from RUN.
    step(1'b0, 1'b1, 64'h100, "to100");
    step(1'b0, 1'b1, 64'h2000, "redir");
    chk("redir_pc", pc, 64'h2000);
    step(1'b0, 1'b0, 64'h0, "after_redir");
    chk("redir_next", pc, 64'h2004);

    // Redirects during stall: newest wins on release.
    step(1'b0, 1'b1, 64'h40, "to40");
    step(1'b1, 1'b1, 64'h500, "st500");
    chk("st500_pend", {63'd0, pend}, 64'd1);
    step(1'b1, 1'b1, 64'h600, "st600");
    step(1'b1, 1'b0, 64'h0, "sthold");
    chk("sthold_pc", pc, 64'h40);
    step(1'b0, 1'b0, 64'h0, "release");
    chk("release_pc", pc, 64'h600);

    // Live redirect beats buffered one.
    step(1'b1, 1'b1, 64'h600, "buf600");
    step(1'b0, 1'b1, 64'h700, "live700");
    chk("live700_pc", pc, 64'h700);

    // Wrap and misaligned target.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "totop");
    step(1'b0, 1'b0, 64'h0, "wrap");
    chk("wrap_pc", pc, 64'h0);
    step(1'b0, 1'b1, 64'h1002, "tomis");
    chk("mis_flag", {63'd0, misalign}, 64'd1);
    step(1'b0, 1'b0, 64'h0, "mis_seq");

    // Reset while a redirect is parked.
    step(1'b1, 1'b1, 64'h900, "buf900");
    reset_pulse("pend_rst");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h900, "post_rst");
    chk("post_rst_pc", pc, 64'h8);

    // Random traffic, including ignored targets and occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      t = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse("rnd");
      end else begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, t, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
